// File: rtl/divider_seq_led.sv
// divider_seq_led: 16-bit restoring sequential divider with 4-digit hex 7-seg encoder (LED_ACTIVE_LOW_EN inverts segments)
module divider_seq_led #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y,
    output logic [15:0] remainder,
    output logic [6:0]  out1,
    output logic [6:0]  out2,
    output logic [6:0]  out3,
    output logic [6:0]  out4
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, nstate;
    logic [WIDTH-1:0] aq, bq, r, q, r_n;
    logic [WIDTH:0] r_sh;
    logic [4:0] cnt;
    logic ge, last, go;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nstate;
    always_comb begin
        go = state != BUSY && start;
        last = cnt == 5'd15;
        r_sh = {r, aq[WIDTH-1]};
        ge = r_sh >= {1'b0, bq};
        r_n = ge ? 16'(r_sh - {1'b0, bq}) : r_sh[WIDTH-1:0];
        nstate = go ? BUSY : (state == BUSY && last) ? DONE : state;
    end
    always_ff @(posedge clk)
        if (rst) begin
            aq <= '0;
            bq <= '0;
            r <= '0;
            q <= '0;
            cnt <= '0;
            y <= '0;
            remainder <= '0;
            done <= 1'b0;
        end else if (go) begin
            aq <= a;
            bq <= b;
            r <= '0;
            q <= '0;
            cnt <= '0;
            done <= 1'b0;
        end else if (state == BUSY) begin
            aq <= aq << 1;
            r <= r_n;
            q <= {q[WIDTH-2:0], ge};
            cnt <= cnt + 5'd1;
            if (last) begin
                y <= {q[WIDTH-2:0], ge};
                remainder <= r_n;
                done <= 1'b1;
            end
        end
    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'h0: v = 7'h3F;
            4'h1: v = 7'h06;
            4'h2: v = 7'h5B;
            4'h3: v = 7'h4F;
            4'h4: v = 7'h66;
            4'h5: v = 7'h6D;
            4'h6: v = 7'h7D;
            4'h7: v = 7'h07;
            4'h8: v = 7'h7F;
            4'h9: v = 7'h6F;
            4'hA: v = 7'h77;
            4'hB: v = 7'h7C;
            4'hC: v = 7'h39;
            4'hD: v = 7'h5E;
            4'hE: v = 7'h79;
            default: v = 7'h71;
        endcase
`ifdef LED_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction
    assign out1 = seg(y[3:0]);
    assign out2 = seg(y[7:4]);
    assign out3 = seg(y[11:8]);
    assign out4 = seg(y[15:12]);
endmodule

// File: tb/tb_divider_seq_led.sv
// tb_divider_seq_led: table-driven self-checking bench for divider_seq_led
module tb_divider_seq_led;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, done;
    logic [15:0] a = '0, b = '0, y, remainder;
    logic [6:0] out1, out2, out3, out4;
    int total = 0, bad = 0;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'h7F;
`else
    localparam logic [6:0] INV = 7'h00;
`endif
    typedef struct {
        logic [15:0] a, b, y, r;
        logic [6:0] o1, o2, o3, o4;
    } vec_t;
    vec_t vt[12];
    divider_seq_led dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .a(a), .b(b),
        .y(y), .remainder(remainder), .out1(out1), .out2(out2), .out3(out3), .out4(out4)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run(input logic [15:0] ta, input logic [15:0] tb, input bit toggle, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        chk("done_clear", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (toggle && lat == 5) start = 1'b1;
            if (toggle && lat == 7) start = 1'b0;
        end
    endtask
    task automatic chk_idle(input string name);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_y"}, 32'(y), 32'd0);
        chk({name, "_rem"}, 32'(remainder), 32'd0);
        chk({name, "_segs"}, {out4, out3, out2, out1}, {4{7'h3F ^ INV}});
    endtask
    initial begin
        int lat;
        logic [15:0] hy, hr;
        vt[0]  = '{110, 25, 4, 10, 7'h66, 7'h3F, 7'h3F, 7'h3F};
        vt[1]  = '{32200, 37, 16'h0366, 10, 7'h7D, 7'h7D, 7'h4F, 7'h3F};
        vt[2]  = '{1234, 56, 16'h0016, 2, 7'h7D, 7'h06, 7'h3F, 7'h3F};
        vt[3]  = '{500, 0, 16'hFFFF, 500, 7'h71, 7'h71, 7'h71, 7'h71};
        vt[4]  = '{65535, 1, 16'hFFFF, 0, 7'h71, 7'h71, 7'h71, 7'h71};
        vt[5]  = '{7, 9, 0, 7, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vt[6]  = '{0, 5, 0, 0, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vt[7]  = '{65535, 65535, 1, 0, 7'h06, 7'h3F, 7'h3F, 7'h3F};
        vt[8]  = '{16'hABCD, 1, 16'hABCD, 0, 7'h5E, 7'h39, 7'h7C, 7'h77};
        vt[9]  = '{40000, 3, 16'h3415, 1, 7'h6D, 7'h06, 7'h66, 7'h4F};
        vt[10] = '{16'h7890, 1, 16'h7890, 0, 7'h3F, 7'h6F, 7'h7F, 7'h07};
        vt[11] = '{16'hE2E2, 1, 16'hE2E2, 0, 7'h5B, 7'h79, 7'h5B, 7'h79};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");
        for (int i = 0; i < 12; i++) begin
            run(vt[i].a, vt[i].b, 1'b0, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd16);
            chk($sformatf("v%0d_y", i), 32'(y), 32'(vt[i].y));
            chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(vt[i].r));
            chk($sformatf("v%0d_segs", i), {out4, out3, out2, out1},
                {vt[i].o4 ^ INV, vt[i].o3 ^ INV, vt[i].o2 ^ INV, vt[i].o1 ^ INV});
        end
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort");
        repeat (20) @(negedge clk);
        chk_idle("abort_quiet");
        run(16'hFFFF, 16'd1, 1'b1, lat);
        chk("toggle_lat", 32'(lat), 32'd16);
        chk("toggle_y", 32'(y), 32'hFFFF);
        chk("toggle_rem", 32'(remainder), 32'd0);
        hy = y;
        hr = remainder;
        #50;
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_y", 32'(y), 32'(hy));
        chk("hold_rem", 32'(remainder), 32'(hr));
        run(16'd110, 16'd25, 1'b0, lat);
        chk("rerun_lat", 32'(lat), 32'd16);
        chk("rerun_y", 32'(y), 32'd4);
        chk("rerun_rem", 32'(remainder), 32'd10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
